timer_counter_8bit: RTL and testbench

// - 8-bit up/down timer/counter with an APB (zero-wait) register interface.
// - Counts rising edges of one of four prescaled tick inputs (pclk/2,/4,/8,/16 from the

---
 rtl/timer_counter_8bit.sv | 124 ++++++++++++
 tb/tb_timer_counter_8bit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_8bit.sv
// 8-bit up/down timer/counter with a zero-wait APB register interface and sticky OVF/UDF flags.
// Optional macro TMR_CNT_READBACK_EN makes TCNT readable at address 0x5.
module timer_counter_8bit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [3:0]            clk_in,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  TMR_OVF,
  output logic                  TMR_UDF
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TDR  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TCR  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TSR  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TCNT = ADDR_WIDTH'(5);

  localparam logic [DATA_WIDTH-1:0] TCR_MASK = DATA_WIDTH'(8'hB3);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  logic [DATA_WIDTH-1:0] r_tdr;
  logic [DATA_WIDTH-1:0] r_tcr;
  logic [1:0]            r_tsr;
  logic [DATA_WIDTH-1:0] r_tcnt;
  logic [3:0]            r_clk_d;

  logic                  w_addr_ok;
  logic                  w_access;
  logic                  w_wr_ok;
  logic                  w_wr_tdr;
  logic                  w_wr_tcr;
  logic                  w_wr_tsr;
  logic                  w_load;
  logic                  w_en;
  logic                  w_down;
  logic [1:0]            w_cks;
  logic                  w_tick;
  logic                  w_step;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic [1:0]            w_tsr_clr;

  // TCNT occupies a legal address only when its readback is compiled in.
`ifdef TMR_CNT_READBACK_EN
  assign w_addr_ok = (paddr == ADDR_TDR) || (paddr == ADDR_TCR) ||
                     (paddr == ADDR_TSR) || (paddr == ADDR_TCNT);
`else
  assign w_addr_ok = (paddr == ADDR_TDR) || (paddr == ADDR_TCR) || (paddr == ADDR_TSR);
`endif

  assign w_access = psel && penable;
  assign pslverr  = w_access && (!w_addr_ok || (pwrite && (paddr == ADDR_TCNT)));
  assign w_wr_ok  = w_access && pwrite && !pslverr;
  assign w_wr_tdr = w_wr_ok && (paddr == ADDR_TDR);
  assign w_wr_tcr = w_wr_ok && (paddr == ADDR_TCR);
  assign w_wr_tsr = w_wr_ok && (paddr == ADDR_TSR);
  assign pready   = 1'b1;

  assign w_load = r_tcr[7];
  assign w_down = r_tcr[5];
  assign w_en   = r_tcr[4];
  assign w_cks  = r_tcr[1:0];

  // All four inputs are sampled every cycle, so switching CKS compares against the new
  // input's own history and cannot fabricate an edge.
  assign w_tick    = clk_in[w_cks] && !r_clk_d[w_cks];
  assign w_step    = !w_load && w_en && w_tick;
  assign w_ovf_set = w_step && !w_down && (r_tcnt == ALL_ONES);
  assign w_udf_set = w_step &&  w_down && (r_tcnt == '0);
  assign w_tsr_clr = w_wr_tsr ? pwdata[1:0] : 2'b00;

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, exactly like the flops it describes.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_tdr   <= '0;
      r_tcr   <= '0;
      r_tsr   <= '0;
      r_tcnt  <= '0;
      r_clk_d <= '0;
    end else begin
      r_clk_d <= clk_in;
      if (w_wr_tdr) r_tdr <= pwdata;
      if (w_wr_tcr) r_tcr <= pwdata & TCR_MASK;

      if (w_load)      r_tcnt <= r_tdr;
      else if (w_step) r_tcnt <= w_down ? (r_tcnt - ONE) : (r_tcnt + ONE);

      // Set terms are OR-ed in after the clear so a coincident event is never lost.
      r_tsr <= (r_tsr & ~w_tsr_clr) | {w_udf_set, w_ovf_set};
    end
  end

  // NOTE: prdata gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite && w_addr_ok) begin
      case (paddr)
        ADDR_TDR:  prdata = r_tdr;
        ADDR_TCR:  prdata = r_tcr;
        ADDR_TSR:  prdata = {{(DATA_WIDTH-2){1'b0}}, r_tsr};
`ifdef TMR_CNT_READBACK_EN
        ADDR_TCNT: prdata = r_tcnt;
`endif
        default:   prdata = '0;
      endcase
    end
  end

  assign TMR_OVF = r_tsr[0];
  assign TMR_UDF = r_tsr[1];

endmodule

// File: tb/tb_timer_counter_8bit.sv
// Self-checking bench for timer_counter_8bit: directed scenarios plus randomized APB
// traffic, checked every cycle against a behavioural model of the register/counter rules.
module tb_timer_counter_8bit;

`ifdef TMR_CNT_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic       pclk     = 1'b0;
  logic       preset_n = 1'b0;
  logic [3:0] clk_in   = '0;
  logic       psel     = 1'b0;
  logic       penable  = 1'b0;
  logic       pwrite   = 1'b0;
  logic [2:0] paddr    = '0;
  logic [7:0] pwdata   = '0;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       TMR_OVF;
  logic       TMR_UDF;

  int         n_checks = 0;
  int         n_errors = 0;
  bit         free_run = 1'b1;
  logic [7:0] div_cnt  = '0;

  timer_counter_8bit dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .clk_in  (clk_in),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .TMR_OVF (TMR_OVF),
    .TMR_UDF (TMR_UDF)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_tdr, m_tcr;
  logic [1:0] m_tsr;
  int         m_tcnt;
  logic [3:0] m_prev_in;

  function automatic bit addr_ok();
    return (paddr inside {3'd2, 3'd3, 3'd4}) || (READBACK && paddr == 3'd5);
  endfunction

  function automatic bit wr_to(input logic [2:0] a);
    return psel && penable && pwrite && paddr == a;
  endfunction

  // The selected prescaler output is high now and was low at the previous pclk.
  function automatic bit m_rising();
    int sel;
    sel = int'(m_tcr[1:0]);
    return clk_in[sel] == 1'b1 && m_prev_in[sel] == 1'b0;
  endfunction

  function automatic bit m_counting();
    return !m_tcr[7] && m_tcr[4] && m_rising();
  endfunction

  function automatic int m_next_count();
    if (m_tcr[7])      return int'(m_tdr);
    if (!m_counting()) return m_tcnt;
    return m_tcr[5] ? (m_tcnt + 255) % 256 : (m_tcnt + 1) % 256;
  endfunction

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      m_tdr     <= '0;
      m_tcr     <= '0;
      m_tsr     <= '0;
      m_tcnt    <= 0;
      m_prev_in <= '0;
    end else begin
      m_prev_in <= clk_in;
      if (wr_to(3'd2)) m_tdr <= pwdata;
      if (wr_to(3'd3)) m_tcr <= pwdata & 8'hB3;
      m_tcnt <= m_next_count();
      m_tsr  <= (wr_to(3'd4) ? (m_tsr & ~pwdata[1:0]) : m_tsr) |
                {m_counting() && m_tcr[5] && m_tcnt == 0,
                 m_counting() && !m_tcr[5] && m_tcnt == 255};
    end
  end

  function automatic logic [7:0] exp_prdata();
    if (!(psel && !pwrite && addr_ok())) return 8'h00;
    case (paddr)
      3'd2:    return m_tdr;
      3'd3:    return m_tcr;
      3'd4:    return {6'b0, m_tsr};
      default: return 8'(m_tcnt);
    endcase
  endfunction

  function automatic logic exp_pslverr();
    return psel && penable && (!addr_ok() || (pwrite && paddr == 3'd5));
  endfunction

  always @(negedge pclk) begin
    check("m_prdata",  prdata,  exp_prdata());
    check("m_pslverr", {7'b0, pslverr}, {7'b0, exp_pslverr()});
    check("m_pready",  {7'b0, pready},  8'h01);
    check("m_ovf",     {7'b0, TMR_OVF}, {7'b0, m_tsr[0]});
    check("m_udf",     {7'b0, TMR_UDF}, {7'b0, m_tsr[1]});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge pclk);
    #1;
    if (free_run) begin
      div_cnt++;
      clk_in = div_cnt[3:0];
    end
  endtask

  task automatic idle_bus();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d, output logic err);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    cyc();
    penable = 1'b1;
    #2 err = pslverr;
    cyc();
    idle_bus();
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic err);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    cyc();
    penable = 1'b1;
    #2;
    d   = prdata;
    err = pslverr;
    cyc();
    idle_bus();
  endtask

  task automatic wait_flag(input bit udf, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((udf ? TMR_UDF : TMR_OVF) == 1'b1) return;
      cyc();
    end
  endtask

  logic [7:0] rd, v1, v2;
  logic       er;

  initial begin
    cyc();
    cyc();
    preset_n = 1'b1;
    cyc();

    // Reset state
    check("rst_ovf", {7'b0, TMR_OVF}, 8'h00);
    check("rst_udf", {7'b0, TMR_UDF}, 8'h00);
    for (int a = 2; a <= 4; a++) begin
      apb_read(3'(a), rd, er);
      check("rst_rd",  rd, 8'h00);
      check("rst_err", {7'b0, er}, 8'h00);
    end

    // Up count from 0xFB on /4 wraps to 0x00 and raises OVF
    apb_write(3'd2, 8'hFB, er);
    apb_write(3'd3, 8'h81, er);
    apb_write(3'd3, 8'h11, er);
    wait_flag(1'b0, 64);
    check("up_ovf", {7'b0, TMR_OVF}, 8'h01);
    check("up_udf", {7'b0, TMR_UDF}, 8'h00);
    apb_write(3'd4, 8'h01, er);
    check("ovf_w1c", {7'b0, TMR_OVF}, 8'h00);

    // Down count from 0x02 on /2 wraps to 0xFF and raises UDF; W1C clears it
    apb_write(3'd2, 8'h02, er);
    apb_write(3'd3, 8'hA0, er);
    apb_write(3'd3, 8'h30, er);
    wait_flag(1'b1, 32);
    check("dn_udf", {7'b0, TMR_UDF}, 8'h01);
    apb_write(3'd4, 8'h02, er);
    check("udf_w1c", {7'b0, TMR_UDF}, 8'h00);

    // EN=0 freezes the count, EN=1 resumes it
    apb_write(3'd3, 8'h01, er);
    apb_read(3'd5, v1, er);
    for (int i = 0; i < 100; i++) cyc();
    apb_read(3'd5, v2, er);
    if (READBACK) check("frozen", v2, v1);
    apb_write(3'd3, 8'h11, er);
    for (int i = 0; i < 40; i++) cyc();
    apb_read(3'd5, v2, er);
    if (READBACK) check("resumed", {7'b0, v2 != v1}, 8'h01);

    // Invalid addresses and TCNT writes error out and change nothing
    apb_write(3'd0, 8'h55, er);
    check("wr0_err", {7'b0, er}, 8'h01);
    apb_write(3'd7, 8'hAA, er);
    check("wr7_err", {7'b0, er}, 8'h01);
    apb_write(3'd5, 8'h77, er);
    check("wr5_err", {7'b0, er}, 8'h01);
    apb_read(3'd7, rd, er);
    check("rd7_err", {7'b0, er}, 8'h01);
    check("rd7_dat", rd, 8'h00);
    apb_read(3'd0, rd, er);
    check("rd0_err", {7'b0, er}, 8'h01);
    apb_read(3'd2, rd, er);
    check("tdr_keep", rd, 8'h02);
    apb_read(3'd3, rd, er);
    check("tcr_keep", rd, 8'h11);
    apb_read(3'd5, rd, er);
    check("rd5_err", {7'b0, er}, READBACK ? 8'h00 : 8'h01);
    if (!READBACK) check("rd5_dat", rd, 8'h00);

    // Overflow coinciding with a TSR W1C of OVF: set must win
    free_run = 1'b0;
    clk_in   = 4'h0;
    apb_write(3'd3, 8'h00, er);
    apb_write(3'd4, 8'h03, er);
    apb_write(3'd2, 8'hFF, er);
    apb_write(3'd3, 8'h80, er);
    apb_write(3'd3, 8'h10, er);
    check("pre_ovf", {7'b0, TMR_OVF}, 8'h00);
    psel = 1'b1; pwrite = 1'b1; paddr = 3'd4; pwdata = 8'h01; penable = 1'b0;
    cyc();
    penable   = 1'b1;
    clk_in[0] = 1'b1;
    cyc();
    idle_bus();
    check("set_wins", {7'b0, TMR_OVF}, 8'h01);
    free_run = 1'b1;

    // Randomized traffic, including held accesses and one mid-run reset
    for (int it = 0; it < 1200; it++) begin
      logic [2:0] a;
      logic [7:0] d;
      int         hold;
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (a == 3'd3 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 1;
      psel = 1'b1; pwrite = 1'($urandom_range(0, 1)); paddr = a; pwdata = d; penable = 1'b0;
      cyc();
      penable = 1'b1;
      for (int h = 0; h < hold; h++) cyc();
      idle_bus();
      for (int k = $urandom_range(0, 6); k > 0; k--) cyc();
      if (it == 600) begin
        #2 preset_n = 1'b0;
        #1;
        check("midrst_ovf", {7'b0, TMR_OVF}, 8'h00);
        check("midrst_udf", {7'b0, TMR_UDF}, 8'h00);
        cyc();
        preset_n = 1'b1;
        apb_read(3'd3, rd, er);
        check("midrst_tcr", rd, 8'h00);
      end
    end

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
